// File: rtl/conv1_ctrl.sv
// Address/enable sequencer for the six-lane conv1 MAC array: walks every valid
// output pixel, issues one image/weight read per tap, then hands the pixel downstream.
module conv1_ctrl #(
    parameter int IN_WIDTH       = 32,
    parameter int IN_HEIGHT      = 32,
    parameter int FILTER_WIDTH   = 5,
    parameter int FILTER_HEIGHT  = 5,
    parameter int FILTER_CHANNEL = 3,
    parameter int ADDR_WIDTH     = 12,
    parameter int WADDR_WIDTH    = 7
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   img_rd_en,
    output logic [ADDR_WIDTH-1:0]  img_addr,
    output logic                   wgt_rd_en,
    output logic [WADDR_WIDTH-1:0] wgt_addr,
    output logic                   mac_clr,
    output logic                   mac_en,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [7:0]             out_row,
    output logic [7:0]             out_col
);
    localparam int OW = IN_WIDTH - FILTER_WIDTH + 1;
    localparam int OH = IN_HEIGHT - FILTER_HEIGHT + 1;
    localparam logic [7:0] KX_LAST  = 8'(FILTER_WIDTH - 1);
    localparam logic [7:0] KY_LAST  = 8'(FILTER_HEIGHT - 1);
    localparam logic [7:0] CH_LAST  = 8'(FILTER_CHANNEL - 1);
    localparam logic [7:0] COL_LAST = 8'(OW - 1);
    localparam logic [7:0] ROW_LAST = 8'(OH - 1);
    // Address jumps when kx wraps, when ky wraps (next channel plane), and between output rows.
    localparam logic [ADDR_WIDTH-1:0] KY_STEP  = ADDR_WIDTH'(IN_WIDTH - FILTER_WIDTH + 1);
    localparam logic [ADDR_WIDTH-1:0] CH_STEP  = ADDR_WIDTH'(IN_WIDTH * IN_HEIGHT
                                                 - (FILTER_HEIGHT - 1) * IN_WIDTH - (FILTER_WIDTH - 1));
    localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(FILTER_WIDTH);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_DRAIN, S_OUTPUT, S_DONE} state_t;
    state_t state_reg, state_next;

    logic [7:0]             kx_reg, ky_reg, ch_reg, row_reg, col_reg;
    logic [ADDR_WIDTH-1:0]  pix_base_reg, img_addr_reg;
    logic [WADDR_WIDTH-1:0] wgt_addr_reg;
    logic                   drain_reg, mac_en_reg, rd_en;
    logic                   last_tap, last_pix;

    assign last_tap = (kx_reg == KX_LAST) && (ky_reg == KY_LAST) && (ch_reg == CH_LAST);
    assign last_pix = (row_reg == ROW_LAST) && (col_reg == COL_LAST);

    always_ff @(posedge clk) begin
        if (reset) state_reg <= S_IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        mac_clr    = 1'b0;
        rd_en      = 1'b0;
        res_valid  = 1'b0;
        case (state_reg)
            S_IDLE:   if (start) state_next = S_CLEAR;
            S_CLEAR: begin
                busy       = 1'b1;
                mac_clr    = 1'b1;
                state_next = S_RUN;
            end
            S_RUN: begin
                busy  = 1'b1;
                rd_en = 1'b1;
                if (last_tap) state_next = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (drain_reg) state_next = S_OUTPUT;
            end
            S_OUTPUT: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                if (res_ready) state_next = last_pix ? S_DONE : S_CLEAR;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            kx_reg       <= '0;
            ky_reg       <= '0;
            ch_reg       <= '0;
            row_reg      <= '0;
            col_reg      <= '0;
            pix_base_reg <= '0;
            img_addr_reg <= '0;
            wgt_addr_reg <= '0;
            drain_reg    <= 1'b0;
            mac_en_reg   <= 1'b0;
        end else begin
            // Data arrives one cycle after the read strobe, so the MAC enable trails it.
            mac_en_reg <= (state_reg == S_RUN);
            case (state_reg)
                S_CLEAR: begin
                    kx_reg       <= '0;
                    ky_reg       <= '0;
                    ch_reg       <= '0;
                    drain_reg    <= 1'b0;
                    img_addr_reg <= pix_base_reg;
                    wgt_addr_reg <= '0;
                end
                S_RUN: if (!last_tap) begin
                    wgt_addr_reg <= wgt_addr_reg + 1'b1;
                    if (kx_reg != KX_LAST) begin
                        kx_reg       <= kx_reg + 8'd1;
                        img_addr_reg <= img_addr_reg + 1'b1;
                    end else if (ky_reg != KY_LAST) begin
                        kx_reg       <= '0;
                        ky_reg       <= ky_reg + 8'd1;
                        img_addr_reg <= img_addr_reg + KY_STEP;
                    end else begin
                        kx_reg       <= '0;
                        ky_reg       <= '0;
                        ch_reg       <= ch_reg + 8'd1;
                        img_addr_reg <= img_addr_reg + CH_STEP;
                    end
                end
                S_DRAIN: drain_reg <= 1'b1;
                S_OUTPUT: if (res_ready) begin
                    if (last_pix) begin
                        row_reg      <= '0;
                        col_reg      <= '0;
                        pix_base_reg <= '0;
                    end else if (col_reg != COL_LAST) begin
                        col_reg      <= col_reg + 8'd1;
                        pix_base_reg <= pix_base_reg + 1'b1;
                    end else begin
                        col_reg      <= '0;
                        row_reg      <= row_reg + 8'd1;
                        pix_base_reg <= pix_base_reg + ROW_STEP;
                    end
                end
                default: ;
            endcase
        end
    end

    assign img_rd_en = rd_en;
    assign wgt_rd_en = rd_en;
    assign img_addr  = img_addr_reg;
    assign wgt_addr  = wgt_addr_reg;
    assign mac_en    = mac_en_reg;
    assign out_row   = row_reg;
    assign out_col   = col_reg;
endmodule

// File: tb/tb_conv1_ctrl.sv
// Scoreboard bench for conv1_ctrl: default 32x32x3 instance plus a 6x6x1 instance,
// expected pixels queued at start and checked tap-by-tap and at each handshake.
module tb_conv1_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, b_start, s_start, ready, sel;

    logic b_busy, b_done, b_img_rd_en, b_wgt_rd_en, b_mac_clr, b_mac_en, b_res_valid;
    logic [11:0] b_img_addr;
    logic [6:0]  b_wgt_addr;
    logic [7:0]  b_out_row, b_out_col;
    logic s_busy, s_done, s_img_rd_en, s_wgt_rd_en, s_mac_clr, s_mac_en, s_res_valid;
    logic [5:0]  s_img_addr;
    logic [4:0]  s_wgt_addr;
    logic [7:0]  s_out_row, s_out_col;

    conv1_ctrl u_big (
        .clk(clk), .reset(reset), .start(b_start), .busy(b_busy), .done(b_done),
        .img_rd_en(b_img_rd_en), .img_addr(b_img_addr), .wgt_rd_en(b_wgt_rd_en),
        .wgt_addr(b_wgt_addr), .mac_clr(b_mac_clr), .mac_en(b_mac_en),
        .res_valid(b_res_valid), .res_ready(ready), .out_row(b_out_row), .out_col(b_out_col)
    );

    conv1_ctrl #(
        .IN_WIDTH(6), .IN_HEIGHT(6), .FILTER_WIDTH(5), .FILTER_HEIGHT(5),
        .FILTER_CHANNEL(1), .ADDR_WIDTH(6), .WADDR_WIDTH(5)
    ) u_small (
        .clk(clk), .reset(reset), .start(s_start), .busy(s_busy), .done(s_done),
        .img_rd_en(s_img_rd_en), .img_addr(s_img_addr), .wgt_rd_en(s_wgt_rd_en),
        .wgt_addr(s_wgt_addr), .mac_clr(s_mac_clr), .mac_en(s_mac_en),
        .res_valid(s_res_valid), .res_ready(ready), .out_row(s_out_row), .out_col(s_out_col)
    );

    // The monitor watches whichever instance is selected.
    logic m_busy, m_done, m_img_rd_en, m_wgt_rd_en, m_mac_clr, m_mac_en, m_res_valid;
    logic [11:0] m_img_addr;
    logic [6:0]  m_wgt_addr;
    logic [7:0]  m_out_row, m_out_col;
    logic [41:0] b_all;
    logic [33:0] s_all;
    assign m_busy      = sel ? s_busy      : b_busy;
    assign m_done      = sel ? s_done      : b_done;
    assign m_img_rd_en = sel ? s_img_rd_en : b_img_rd_en;
    assign m_wgt_rd_en = sel ? s_wgt_rd_en : b_wgt_rd_en;
    assign m_mac_clr   = sel ? s_mac_clr   : b_mac_clr;
    assign m_mac_en    = sel ? s_mac_en    : b_mac_en;
    assign m_res_valid = sel ? s_res_valid : b_res_valid;
    assign m_img_addr  = sel ? {6'd0, s_img_addr} : b_img_addr;
    assign m_wgt_addr  = sel ? {2'd0, s_wgt_addr} : b_wgt_addr;
    assign m_out_row   = sel ? s_out_row : b_out_row;
    assign m_out_col   = sel ? s_out_col : b_out_col;
    assign b_all = {b_busy, b_done, b_img_rd_en, b_img_addr, b_wgt_rd_en, b_wgt_addr,
                    b_mac_clr, b_mac_en, b_res_valid, b_out_row, b_out_col};
    assign s_all = {s_busy, s_done, s_img_rd_en, s_img_addr, s_wgt_rd_en, s_wgt_addr,
                    s_mac_clr, s_mac_en, s_res_valid, s_out_row, s_out_col};

    int iw, ih, fw, fh, fc, taps;
    logic [15:0] pix_q[$];
    int cyc, start_cyc, clr_cyc, tap_i, mac_cnt, done_cnt, done_cyc;
    bit first_clr, prev_valid;
    int n_cmp, n_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [15:0] p;
        int ch, rem, ky, kx;
        cyc++;
        if (reset) begin
            tap_i = 0;
            mac_cnt = 0;
            prev_valid = 0;
            pix_q.delete();
        end else begin
            if (m_mac_clr) begin
                check("clr_vs_mac_en", 64'(m_mac_en), 0);
                if (first_clr) begin
                    check("start_to_clr", 64'(cyc - start_cyc), 1);
                    first_clr = 0;
                end
                tap_i = 0;
                mac_cnt = 0;
                clr_cyc = cyc;
            end
            if (m_mac_en) mac_cnt++;
            if (m_img_rd_en) begin
                if (pix_q.size() == 0) check("rd_without_pixel", 1, 0);
                else begin
                    p   = pix_q[0];
                    ch  = tap_i / (fw * fh);
                    rem = tap_i % (fw * fh);
                    ky  = rem / fw;
                    kx  = rem % fw;
                    check("img_addr", 64'(m_img_addr),
                          64'(ch * iw * ih + (int'(p[15:8]) + ky) * iw + int'(p[7:0]) + kx));
                    check("wgt_addr", 64'(m_wgt_addr), 64'(tap_i));
                    check("wgt_rd_en", 64'(m_wgt_rd_en), 1);
                end
                tap_i++;
            end
            if (m_res_valid) begin
                if (!prev_valid) begin
                    check("clr_to_valid", 64'(cyc - clr_cyc), 64'(taps + 3));
                    check("mac_en_count", 64'(mac_cnt), 64'(taps));
                end
                if (pix_q.size() == 0) check("valid_without_pixel", 1, 0);
                else begin
                    p = pix_q[0];
                    check("out_row", 64'(m_out_row), 64'(p[15:8]));
                    check("out_col", 64'(m_out_col), 64'(p[7:0]));
                    if (ready) void'(pix_q.pop_front());
                end
                if (!ready) check("stall_quiet", 64'({m_img_rd_en, m_mac_en, m_mac_clr}), 0);
            end
            prev_valid = m_res_valid && !ready;
            if (m_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic launch();
        for (int r = 0; r < ih - fh + 1; r++)
            for (int c = 0; c < iw - fw + 1; c++)
                pix_q.push_back({8'(r), 8'(c)});
        taps = fc * fh * fw;
        done_cnt = 0;
        first_clr = 1;
        @(posedge clk); #1;
        start_cyc = cyc + 1;
        if (sel) s_start = 1'b1; else b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        s_start = 1'b0;
    endtask

    initial begin
        int k, npix;
        bit stalled, hit;
        reset = 1'b1; b_start = 1'b0; s_start = 1'b0; ready = 1'b1; sel = 1'b0;
        iw = 32; ih = 32; fw = 5; fh = 5; fc = 3; taps = 75;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outs_big", 64'(b_all), 0);
        check("reset_outs_small", 64'(s_all), 0);
        @(posedge clk); #1 reset = 1'b0;

        // Full frame with a 10-cycle stall at (0,3) and a stray start mid-frame.
        launch();
        k = 0; stalled = 0;
        while (done_cnt == 0 && k < 70000) begin
            @(posedge clk); #1; k++;
            b_start = (k == 500);
            if (!stalled && m_res_valid && m_out_row == 8'd0 && m_out_col == 8'd3) begin
                stalled = 1;
                ready = 1'b0;
                repeat (10) @(posedge clk);
                #1 ready = 1'b1;
            end
        end
        b_start = 1'b0;
        repeat (5) @(posedge clk); #1;
        check("frame_done_count", 64'(done_cnt), 1);
        check("frame_done_time", 64'(done_cyc - start_cyc), 61937 + 10);
        check("frame_pixels_left", 64'(pix_q.size()), 0);
        check("stall_happened", 64'(stalled), 1);
        check("idle_after_frame", 64'(b_busy), 0);

        // Reset during RUN tap 40 of pixel (2,5), then restart from (0,0).
        launch();
        k = 0; hit = 0;
        while (!hit && k < 10000) begin
            @(posedge clk); #1; k++;
            if (m_img_rd_en && pix_q.size() > 0 && pix_q[0] == {8'd2, 8'd5} && tap_i == 40) hit = 1;
        end
        check("reset_point_reached", 64'(hit), 1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_run_reset_outs", 64'(b_all), 0);
        @(posedge clk); #1 reset = 1'b0;
        launch();
        npix = pix_q.size();
        k = 0;
        while (pix_q.size() == npix && k < 200) begin
            @(posedge clk); #1; k++;
        end
        check("restart_first_pixel", 64'(npix - pix_q.size()), 1);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Small 6x6x1 instance: 2x2 outputs of 25 taps.
        sel = 1'b1;
        iw = 6; ih = 6; fw = 5; fh = 5; fc = 1;
        launch();
        k = 0;
        while (done_cnt == 0 && k < 500) begin
            @(posedge clk); #1; k++;
        end
        repeat (3) @(posedge clk); #1;
        check("small_done_count", 64'(done_cnt), 1);
        check("small_done_time", 64'(done_cyc - start_cyc), 4 * 29 + 1);
        check("small_pixels_left", 64'(pix_q.size()), 0);
        check("small_idle", 64'(s_busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/conv1_ctrl.md
# conv1_ctrl

Sequencer for the six-filter first convolution layer (six parallel 5x5xC multiply-accumulate lanes sharing one input-feature stream). Walks every valid output pixel of an IN_WIDTH x IN_HEIGHT x FILTER_CHANNEL input map and generates the read addresses for the image buffer and the six per-filter weight banks. Clears and enables the MAC lanes in step with read latency, and presents each finished pixel to the downstream pooling stage through a valid/ready handshake. Sits between the layer's on-chip buffers and the conv1 MAC array; controlled by the network top-level FSM through start/busy/done.

## Interface
- IN_WIDTH, 32, input map width (columns)
- IN_HEIGHT, 32, input map height (rows)
- FILTER_WIDTH, 5, kernel width
- FILTER_HEIGHT, 5, kernel height
- FILTER_CHANNEL, 3, input channels
- ADDR_WIDTH, 12, image address width; must hold FILTER_CHANNEL*IN_WIDTH*IN_HEIGHT-1
- WADDR_WIDTH, 7, weight address width; must hold FILTER_CHANNEL*FILTER_WIDTH*FILTER_HEIGHT-1

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin a frame; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last pixel is accepted
- img_rd_en  out  1  image buffer read strobe
- img_addr  out  ADDR_WIDTH  image read address
- wgt_rd_en  out  1  weight bank read strobe (common to all six banks)
- wgt_addr  out  WADDR_WIDTH  weight read address (common to all six banks)
- mac_clr  out  1  zero all six accumulators
- mac_en  out  1  accumulate current data/weight pair in all six lanes
- res_valid  out  1  six lane results hold a finished pixel
- res_ready  in  1  downstream accepts the pixel
- out_row  out  8  output row of the presented pixel
- out_col  out  8  output column of the presented pixel

## Operation
- Output map: OW = IN_WIDTH-FILTER_WIDTH+1, OH = IN_HEIGHT-FILTER_HEIGHT+1 (28x28 by default). Pixels run in raster order: col fastest, then row.
- Per pixel, TAPS = FILTER_CHANNEL*FILTER_HEIGHT*FILTER_WIDTH (75). Tap order is kx fastest, then ky, then ch.
- Address formulas:
  - img_addr = ch*IN_WIDTH*IN_HEIGHT + (row+ky)*IN_WIDTH + (col+kx)
  - wgt_addr = ch*FILTER_HEIGHT*FILTER_WIDTH + ky*FILTER_WIDTH + kx
  - Generate both with incremental counters and adders, no multipliers.
- FSM states:
  - IDLE: outputs low. start=1 -> CLEAR.
  - CLEAR: 1 cycle, mac_clr=1 -> RUN.
  - RUN: TAPS cycles. Each cycle asserts img_rd_en/wgt_rd_en and issues one tap; after the last tap -> DRAIN.
  - DRAIN: 2 cycles (buffer read latency 1 + MAC register 1) -> OUTPUT.
  - OUTPUT: res_valid=1 with out_row/out_col stable until res_ready=1. On acceptance, the last pixel -> DONE; otherwise advance col/row -> CLEAR.
  - DONE: 1 cycle, done=1 -> IDLE.
- mac_en is img_rd_en delayed one cycle, so exactly TAPS mac_en pulses per pixel. mac_clr never overlaps mac_en.
- start outside IDLE is ignored. res_ready outside OUTPUT is ignored.
- reset at any point (including mid-RUN or mid-OUTPUT): next state IDLE, all counters zero, pending pixel discarded.

## Timing
- Reset values: every output 0 (busy, done, img_rd_en, img_addr, wgt_rd_en, wgt_addr, mac_clr, mac_en, res_valid, out_row, out_col).
- start sampled at edge N -> mac_clr high in cycle N+1 -> first rd_en in N+2 -> first mac_en in N+3.
- Per-pixel latency CLEAR-to-res_valid = 1+TAPS+2 = 78 cycles. With res_ready held high, one pixel every 79 cycles; a frame of 784 pixels takes 61936 cycles plus 1 for DONE.
- res_valid is asserted in the first OUTPUT cycle. The handshake completes on the edge where res_valid && res_ready. res_valid drops in the next cycle (CLEAR of the next pixel, or DONE).
- done pulses in the cycle after the final handshake; busy falls in the same cycle.
- Address outputs are registered; values change only in RUN and hold their last value elsewhere (reset to 0).

## Test plan
- Single pixel, default params, res_ready=1: first 75 img_addr = 0..4, 32..36, ..., 128..132, 1024..1028, ...; wgt_addr = 0..74; 75 mac_en pulses; res_valid 78 cycles after mac_clr, out_row=0, out_col=0.
- Full frame, res_ready=1: exactly 784 handshakes in raster order, last at (27,27) with img_addr base 27*32+27=891; done pulses once, 61937 cycles after start.
- Backpressure: hold res_ready=0 for 10 cycles at pixel (0,3) -> res_valid, out_row=0, out_col=3 stable; no rd_en/mac_en/mac_clr during the stall; pixel (0,4) follows after release.
- Reset at RUN tap 40 of pixel (2,5) -> next cycle all outputs 0, IDLE; new start restarts at (0,0), wgt_addr 0.
- start pulsed while busy -> ignored; pixel sequence and done timing unchanged.
- Small config IN 6x6, FILTER_CHANNEL=1 -> 2x2 outputs, 25 taps each; pixel (1,1) img_addr 7..11, 13..17, ..., 31..35; done after 4 handshakes.
